ir_cmd_controller: RTL and testbench



---
 rtl/ir_cmd_controller_pkg.sv | 24 ++
 rtl/ir_cmd_controller_frame_check.sv | 40 ++++
 rtl/ir_cmd_controller.sv | 145 ++++++++++++++
 tb/tb_ir_cmd_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_cmd_controller_pkg.sv
// Shared types and constants for the NEC IR command controller:
// FSM states, command bytes, button indices and the repeatable set.
package ir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] CMD_MUTE  = 8'h30;
  localparam logic [7:0] CMD_PLAY  = 8'h18;
  localparam logic [7:0] CMD_NEXT  = 8'h7A;
  localparam logic [7:0] CMD_RESET = 8'h10;

  localparam logic [1:0] IDX_MUTE  = 2'd0;
  localparam logic [1:0] IDX_PLAY  = 2'd1;
  localparam logic [1:0] IDX_NEXT  = 2'd2;
  localparam logic [1:0] IDX_RESET = 2'd3;

  // Only NEXT may be auto-fired again by NEC repeat codes.
  localparam logic [3:0] REPEAT_MASK = 4'b0100;

endpackage

// File: rtl/ir_cmd_controller_frame_check.sv
// Combinational NEC frame validation (complement bytes, optional address
// filter) and mapping of the command byte onto a button index.
module ir_frame_check
  import ir_pkg::*;
#(
  parameter bit         ADDR_CHECK = 1'b1,
  parameter logic [7:0] ADDR       = 8'h00
) (
  input  logic [31:0] data,
  output logic        ok,
  output logic        hit,
  output logic [1:0]  idx,
  output logic        repeatable,
  output logic [7:0]  cmd
);

  logic [7:0] naddr;
  logic [7:0] addr;
  logic [7:0] ncmd;

  always_comb begin
    naddr = data[31:24];
    addr  = data[23:16];
    cmd   = data[15:8];
    ncmd  = data[7:0];
    ok    = (cmd == ~ncmd) && (addr == ~naddr) && (!ADDR_CHECK || addr == ADDR);

    hit = 1'b1;
    idx = IDX_MUTE;
    case (cmd)
      CMD_MUTE:  idx = IDX_MUTE;
      CMD_PLAY:  idx = IDX_PLAY;
      CMD_NEXT:  idx = IDX_NEXT;
      CMD_RESET: idx = IDX_RESET;
      default:   hit = 1'b0;
    endcase
    repeatable = hit && REPEAT_MASK[idx];
  end

endmodule

// File: rtl/ir_cmd_controller.sv
// Turns validated NEC frames and repeat codes into fixed-width active-low
// button pulses with a guaranteed all-high gap between pulses.
module ir_cmd_controller
  import ir_pkg::*;
#(
  parameter int         PULSE_CYC      = 2_500_000,
  parameter int         GAP_CYC        = 500_000,
  parameter int         REPEAT_WIN_CYC = 6_000_000,
  parameter int         ADDR_CHECK     = 1,
  parameter logic [7:0] ADDR           = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_valid,
  input  logic [31:0] frame_data,
  input  logic        repeat_valid,
  output logic [3:0]  botao_n,
  output logic [7:0]  cmd_code,
  output logic        cmd_accepted,
  output logic        frame_err,
  output logic        busy
);

  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int WW      = $clog2(REPEAT_WIN_CYC + 1);

  logic          chk_ok, chk_hit, chk_rep;
  logic [1:0]    chk_idx;
  logic [7:0]    chk_cmd;

  logic          frame_ok, frame_bad, win_open, repeat_hit, load_pend, consume;
  logic [1:0]    load_idx;
  logic          pend, last_rep;
  logic [1:0]    pend_idx, last_idx, cur_idx, cur_idx_next;
  logic [WW-1:0] win_cnt;
  logic [CW-1:0] cnt, cnt_next;
  state_t        state, state_next;

  ir_frame_check #(
    .ADDR_CHECK (ADDR_CHECK != 0),
    .ADDR       (ADDR)
  ) u_check (
    .data       (frame_data),
    .ok         (chk_ok),
    .hit        (chk_hit),
    .idx        (chk_idx),
    .repeatable (chk_rep),
    .cmd        (chk_cmd)
  );

  // A frame in the same cycle as a repeat code always takes priority.
  assign frame_ok   = frame_valid && chk_ok;
  assign frame_bad  = frame_valid && !chk_ok;
  assign win_open   = (win_cnt != '0);
  assign repeat_hit = repeat_valid && !frame_valid && win_open && last_rep;
  assign load_pend  = (frame_ok && chk_hit) || repeat_hit;
  assign load_idx   = frame_ok ? chk_idx : last_idx;
  assign consume    = (state == IDLE) && pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_accepted <= 1'b0;
      frame_err    <= 1'b0;
      cmd_code     <= 8'h00;
      last_idx     <= 2'd0;
      last_rep     <= 1'b0;
      pend         <= 1'b0;
      pend_idx     <= 2'd0;
      win_cnt      <= '0;
    end else begin
      cmd_accepted <= frame_ok;
      frame_err    <= frame_bad;
      if (frame_ok) begin
        cmd_code <= chk_cmd;
        last_idx <= chk_idx;
        last_rep <= chk_rep;
      end
      // A new load overwrites any entry still waiting in the one-deep slot.
      if (load_pend) begin
        pend     <= 1'b1;
        pend_idx <= load_idx;
      end else if (consume) begin
        pend <= 1'b0;
      end
      if (load_pend)
        win_cnt <= WW'(REPEAT_WIN_CYC);
      else if (frame_ok)
        win_cnt <= '0;
      else if (win_open)
        win_cnt <= win_cnt - WW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_idx <= 2'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      cur_idx <= cur_idx_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    cur_idx_next = cur_idx;
    case (state)
      IDLE: begin
        if (pend) begin
          state_next   = PULSE;
          cnt_next     = CW'(PULSE_CYC - 1);
          cur_idx_next = pend_idx;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_next = GAP;
          cnt_next   = CW'(GAP_CYC - 1);
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0)
          state_next = IDLE;
        else
          cnt_next = cnt - CW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // Decoded from the state register so reset forces the buttons high at once.
  always_comb begin
    botao_n = 4'b1111;
    if (state == PULSE)
      botao_n[cur_idx] = 1'b0;
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_ir_cmd_controller.sv
// Directed self-checking bench for ir_cmd_controller with short timing
// parameters so full pulse/gap/window sequences fit in a few thousand cycles.
module tb_ir_cmd_controller;

  localparam int PULSE = 20;
  localparam int GAP   = 5;
  localparam int WIN   = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_valid = 1'b0;
  logic        repeat_valid = 1'b0;
  logic [31:0] frame_data = 32'h0;
  logic [3:0]  botao_n;
  logic [7:0]  cmd_code;
  logic        cmd_accepted;
  logic        frame_err;
  logic        busy;

  int tests = 0;
  int fails = 0;

  int         pulses = 0;
  int         multi_low = 0;
  int         cur_w = 0;
  int         hi_run = 0;
  logic [3:0] prev_b = 4'hF;
  logic [3:0] pat_q[$];
  int         w_q[$];
  int         gap_q[$];

  ir_cmd_controller #(
    .PULSE_CYC      (PULSE),
    .GAP_CYC        (GAP),
    .REPEAT_WIN_CYC (WIN),
    .ADDR_CHECK     (1),
    .ADDR           (8'h00)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_valid  (frame_valid),
    .frame_data   (frame_data),
    .repeat_valid (repeat_valid),
    .botao_n      (botao_n),
    .cmd_code     (cmd_code),
    .cmd_accepted (cmd_accepted),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Records every pulse: pattern, width and the all-high run before it.
  always @(negedge clk) begin
    if ($countones(~botao_n) > 1) multi_low++;
    if (botao_n != 4'hF) begin
      if (prev_b == 4'hF) begin
        pulses++;
        pat_q.push_back(botao_n);
        gap_q.push_back(hi_run);
        cur_w = 1;
      end else begin
        cur_w++;
      end
    end else begin
      if (prev_b != 4'hF) begin
        w_q.push_back(cur_w);
        hi_run = 1;
      end else begin
        hi_run++;
      end
    end
    prev_b = botao_n;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input logic fv, input logic rv, input logic [31:0] d);
    frame_valid  = fv;
    repeat_valid = rv;
    frame_data   = d;
    tick();
    frame_valid  = 1'b0;
    repeat_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int w;
    int g;
    int b;
    int qb;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_botao", 32'(botao_n), 'hF);
    checkOutput("rst_code", 32'(cmd_code), 'h0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_acc", 32'(cmd_accepted), 0);
    checkOutput("rst_err", 32'(frame_err), 0);
    rst_n = 1'b1;
    idle(2);

    // MUTE frame: exact latency, width and busy span
    applyStimulus(1'b1, 1'b0, 32'hFF00_30CF);
    checkOutput("t1_acc", 32'(cmd_accepted), 1);
    checkOutput("t1_code", 32'(cmd_code), 'h30);
    checkOutput("t1_err", 32'(frame_err), 0);
    checkOutput("t1_not_yet", 32'(botao_n), 'hF);
    tick();
    checkOutput("t1_acc_1cyc", 32'(cmd_accepted), 0);
    checkOutput("t1_start", 32'(botao_n), 'hE);
    checkOutput("t1_busy", 32'(busy), 1);
    w = 0;
    while (botao_n == 4'b1110 && w < 200) begin
      w++;
      tick();
    end
    checkOutput("t1_width", 32'(w), PULSE);
    g = 0;
    while (busy && g < 200) begin
      g++;
      tick();
    end
    checkOutput("t1_busy_total", 32'(w + g), PULSE + GAP);

    // Rejected frames: bad cmd complement, bad addr complement, wrong address
    b = pulses;
    applyStimulus(1'b1, 1'b0, 32'hFF00_7A84);
    checkOutput("t2_err", 32'(frame_err), 1);
    checkOutput("t2_acc", 32'(cmd_accepted), 0);
    checkOutput("t2_code", 32'(cmd_code), 'h30);
    tick();
    checkOutput("t2_err_1cyc", 32'(frame_err), 0);
    applyStimulus(1'b1, 1'b0, 32'hFF01_30CF);
    checkOutput("t2_naddr_err", 32'(frame_err), 1);
    applyStimulus(1'b1, 1'b0, 32'hFE01_30CF);
    checkOutput("t2_addr_filter_err", 32'(frame_err), 1);
    checkOutput("t2_addr_filter_acc", 32'(cmd_accepted), 0);
    idle(30);
    checkOutput("t2_no_pulse", 32'(pulses - b), 0);

    // NEXT + honoured repeat at +60, expired repeat at +260
    b = pulses;
    qb = pat_q.size();
    applyStimulus(1'b1, 1'b0, 32'hFF00_7A85);
    idle(59);
    applyStimulus(1'b0, 1'b1, 32'h0);
    idle(199);
    applyStimulus(1'b0, 1'b1, 32'h0);
    idle(100);
    checkOutput("t3_pulses", 32'(pulses - b), 2);
    if (pat_q.size() >= qb + 2) begin
      checkOutput("t3_pat0", 32'(pat_q[qb]), 'hB);
      checkOutput("t3_pat1", 32'(pat_q[qb+1]), 'hB);
      checkOutput("t3_w1", 32'(w_q[qb+1]), PULSE);
    end

    // MUTE is not repeatable
    b = pulses;
    applyStimulus(1'b1, 1'b0, 32'hFF00_30CF);
    idle(29);
    applyStimulus(1'b0, 1'b1, 32'h0);
    idle(80);
    checkOutput("t4_pulses", 32'(pulses - b), 1);

    // PLAY, then RESET overwritten in the slot by MUTE
    b = pulses;
    qb = pat_q.size();
    applyStimulus(1'b1, 1'b0, 32'hFF00_18E7);
    idle(2);
    applyStimulus(1'b1, 1'b0, 32'hFF00_10EF);
    idle(4);
    applyStimulus(1'b1, 1'b0, 32'hFF00_30CF);
    idle(60);
    checkOutput("t5_pulses", 32'(pulses - b), 2);
    if (pat_q.size() >= qb + 2) begin
      checkOutput("t5_pat0", 32'(pat_q[qb]), 'hD);
      checkOutput("t5_pat1", 32'(pat_q[qb+1]), 'hE);
      checkOutput("t5_w0", 32'(w_q[qb]), PULSE);
      // GAP cycles plus the one IDLE cycle that dispatches the next pulse
      checkOutput("t5_gap", 32'(gap_q[qb+1]), GAP + 1);
    end

    // Unmapped valid command closes the window
    applyStimulus(1'b1, 1'b0, 32'hFF00_7A85);
    idle(40);
    applyStimulus(1'b1, 1'b0, 32'hFF00_45BA);
    checkOutput("t7_acc", 32'(cmd_accepted), 1);
    checkOutput("t7_code", 32'(cmd_code), 'h45);
    b = pulses;
    idle(5);
    applyStimulus(1'b0, 1'b1, 32'h0);
    idle(40);
    checkOutput("t7_no_pulse", 32'(pulses - b), 0);

    // Frame and repeat together: frame wins
    applyStimulus(1'b1, 1'b0, 32'hFF00_7A85);
    idle(40);
    b = pulses;
    qb = pat_q.size();
    applyStimulus(1'b1, 1'b1, 32'hFF00_18E7);
    checkOutput("t8_code", 32'(cmd_code), 'h18);
    idle(40);
    checkOutput("t8_pulses", 32'(pulses - b), 1);
    if (pat_q.size() >= qb + 1)
      checkOutput("t8_pat", 32'(pat_q[qb]), 'hD);

    // Asynchronous reset in the middle of a RESET pulse
    applyStimulus(1'b1, 1'b0, 32'hFF00_10EF);
    idle(10);
    checkOutput("t6_mid_pulse", 32'(botao_n), 'h7);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_botao", 32'(botao_n), 'hF);
    checkOutput("t6_async_busy", 32'(busy), 0);
    checkOutput("t6_async_code", 32'(cmd_code), 'h0);
    idle(2);
    b = pulses;
    rst_n = 1'b1;
    idle(40);
    checkOutput("t6_no_resume", 32'(pulses - b), 0);
    checkOutput("t6_busy", 32'(busy), 0);
    checkOutput("t6_botao", 32'(botao_n), 'hF);

    checkOutput("one_low_max", 32'(multi_low), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
